// File: rtl/bus_fifo_buffer_if.sv
// Valid/ready bus bundle for the FIFO: producer side (in_*) and consumer side (out_*).
// The FIFO itself connects through the slave modport. The environment driving the
// producer and consumer connects through the master modport.
interface bus_fifo_buffer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/bus_fifo_buffer.sv
// DEPTH-entry, WIDTH-bit synchronous FIFO with valid/ready on both sides.
// The output is first-word-fall-through and is read straight from storage, so a word
// written at edge N becomes visible after that edge. There is no bypass when the FIFO is empty.
// in_ready depends only on the registered count. As a result, a full FIFO refuses a write
// even in a cycle where a pop frees an entry. This keeps out_ready off the in_ready path.
// flush clears the pointers and the count, and it overrides a concurrent push or pop.
// flush leaves storage untouched. Only reset zeroes storage.
module bus_fifo_buffer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  bus_fifo_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Handshake qualifiers are derived from registered state only.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  // Next-state logic for the pointers and the count. Pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write. Reset zeroes every entry. flush suppresses the write but leaves old contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CW'(AFULL_LVL));

endmodule

// File: doc/bus_fifo_buffer.md
Name: bus_fifo_buffer

Overview:
Parametrised successor to the single-register write-enable buffer: a synchronous DEPTH-entry, WIDTH-bit FIFO with valid/ready handshakes on both sides. It decouples a bus producer from its consumer and absorbs back-pressure bursts. Output is first-word-fall-through, registered from storage. It also provides a level count, an almost-full flag and a synchronous flush.

Parameters:
WIDTH, 16, data width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
AFULL_LVL, DEPTH-1, almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of all queued entries
in_valid  input  1  producer has data on in_data
in_ready  output  1  FIFO can accept a word this cycle
in_data  input  WIDTH  write data
out_valid  output  1  out_data holds the oldest queued word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  oldest queued word
count  output  $clog2(DEPTH)+1  number of queued entries, 0..DEPTH
almost_full  output  1  count >= AFULL_LVL

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, all storage entries cleared to 0. Outputs: out_valid=0, in_ready=1, out_data=0, almost_full=0.
- Reset release mid-transfer: nothing is retained. The first push after release lands in entry 0.
- push = in_valid & in_ready. On push: mem[wr_ptr] <= in_data and wr_ptr increments.
- pop = out_valid & out_ready. On pop: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special-casing.
- count update: next = count + push - pop.
  - push & pop in the same cycle: count unchanged, both pointers advance.
- in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
  - When full, a simultaneous pop does NOT allow a push in that cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr].
  - out_data is driven directly from storage (FWFT) and is stable while out_valid=1 and out_ready=0.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, i.e. one cycle. There is no combinational in->out bypass when empty.
- Empty with out_ready=1: no pop. rd_ptr and count hold, out_data is don't-care.
- Full with in_valid=1: no push. The write is ignored and in_data is not sampled.
- almost_full is combinational from count; it has no hysteresis.
- flush=1 at an edge:
  - wr_ptr, rd_ptr and count go to 0.
  - It dominates any concurrent push/pop; a word presented in that cycle is dropped.
  - Storage contents are not cleared.
  - After the edge: out_valid=0, in_ready=1.
- Protocol: the producer must hold in_valid/in_data until in_ready. The FIFO does not check this.
- Data integrity: words leave in exact push order with no loss or duplication, except where dropped by flush or reset.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with count=3 -> immediately count=0, out_valid=0, in_ready=1, out_data=0, almost_full=0.
- Fill/drain: DEPTH=4, out_ready=0, push 0x1111..0x4444 on consecutive cycles.
  - After 4th edge: count=4, in_ready=0, almost_full=1 (after 3rd edge already 1).
  - Then out_ready=1 -> 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles, then out_valid=0.
- Latency: push 0xABCD into empty FIFO at edge N -> out_valid=1, out_data=0xABCD after edge N and not before.
- Simultaneous push/pop: count=2, in_valid=out_ready=1 for 10 cycles with incrementing data -> count stays 2, output order equals input order, pointers wrap past 3 correctly.
- Full with pop: count=4, in_valid=1, out_ready=1 -> one word popped, input not accepted that cycle (count=3). Accepted next cycle (count=4).
- Flush: count=3, flush=1 with in_valid=1, in_data=0x5A5A -> next cycle count=0, out_valid=0. Subsequent push 0x1234 appears as the first output (0x5A5A never emerges).
